// File: rtl/if_fetch_predict.sv
// MIPS instruction-fetch stage: PC register, 2-bit BHT branch predictor, next-PC selection.
// Define BHT_BYPASS_EN to let a same-cycle BHT update to the fetched PC's entry steer predict/predictionbuffer.
module if_fetch_predict #(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ins,
  output logic [31:0] pcaddr1,
  output logic [31:0] branchaddr1,
  output logic [31:0] signextendresult,
  output logic        predict,
  output logic [1:0]  predictionbuffer,
  output logic        if_flush
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [31:0]    pc_q, pc_d;
  logic [1:0]     bht_q [BHT_ENTRIES];
  logic [1:0]     bht_d [BHT_ENTRIES];
  logic [IDX-1:0] rd_idx_s, up_idx_s;
  logic [1:0]     ctr_rd_s;
  logic [5:0]     opcode_s;
  logic           is_br_s, is_j_s;
  logic           upd_pc_unused;

  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case (ctr)
      2'b00:   res = taken ? 2'b01 : 2'b00;
      2'b01:   res = taken ? 2'b10 : 2'b00;
      2'b10:   res = taken ? 2'b11 : 2'b01;
      2'b11:   res = taken ? 2'b11 : 2'b10;
      default: res = 2'b01;
    endcase
    return res;
  endfunction

  assign rd_idx_s      = pc_q[IDX+1:2];
  assign up_idx_s      = upd_pc[IDX+1:2];
  assign upd_pc_unused = ^{upd_pc[31:IDX+2], upd_pc[1:0]};

  assign opcode_s = imem_data[31:26];
  assign is_br_s  = (opcode_s == 6'h04) || (opcode_s == 6'h05);
  assign is_j_s   = (opcode_s == 6'h02);

  assign imem_addr        = pc_q;
  assign ins              = imem_data;
  assign pcaddr1          = pc_q + 32'd4;
  assign signextendresult = {{16{imem_data[15]}}, imem_data[15:0]};
  assign branchaddr1      = pcaddr1 + {signextendresult[29:0], 2'b00};
  assign if_flush         = redirect_valid;
  assign predictionbuffer = ctr_rd_s;
  assign predict          = is_br_s & ctr_rd_s[1];

  // Counter read for the fetched PC, optionally forwarding a same-index update.
  always_comb begin
    ctr_rd_s = bht_q[rd_idx_s];
`ifdef BHT_BYPASS_EN
    if (upd_valid && (up_idx_s == rd_idx_s)) begin
      ctr_rd_s = sat_next(bht_q[up_idx_s], upd_taken);
    end else begin
      ctr_rd_s = bht_q[rd_idx_s];
    end
`endif
  end

  // Next-PC selection: redirect beats stall, stall beats prediction and jumps.
  always_comb begin
    pc_d = pcaddr1;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else if (predict) begin
      pc_d = branchaddr1;
    end else if (is_j_s) begin
      pc_d = {pcaddr1[31:28], imem_data[25:0], 2'b00};
    end else begin
      pc_d = pcaddr1;
    end
  end

  // BHT training, independent of stall and redirect.
  always_comb begin
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (upd_valid) begin
      bht_d[up_idx_s] = sat_next(bht_q[up_idx_s], upd_taken);
    end else begin
      bht_d[up_idx_s] = bht_q[up_idx_s];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_predict.sv
// Bench for if_fetch_predict: directed vector table followed by random stimulus against a behavioural model.
module tb_if_fetch_predict;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NENT   = 64;

  logic        clk = 1'b0;
  logic        rst_n, pc_write, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, imem_data;
  logic [31:0] imem_addr, ins, pcaddr1, branchaddr1, signextendresult;
  logic        predict, if_flush;
  logic [1:0]  predictionbuffer;

  int n_pass = 0;
  int n_total = 0;

  // model state
  logic [31:0] m_pc;
  int          m_ctr [NENT];

  typedef struct {
    logic        chk;
    logic        rstn, pw, rv, uv, ut;
    logic [31:0] rpc, upc, data;
    logic [31:0] e_addr, e_pa1, e_ba1;
    logic [1:0]  e_pb;
    logic        e_pred, e_flush;
  } vec_t;

  vec_t vt [24];

  if_fetch_predict #(.BHT_ENTRIES(NENT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .imem_addr(imem_addr), .imem_data(imem_data), .ins(ins),
    .pcaddr1(pcaddr1), .branchaddr1(branchaddr1),
    .signextendresult(signextendresult), .predict(predict),
    .predictionbuffer(predictionbuffer), .if_flush(if_flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic chk, input logic rstn, input logic pw, input logic rv,
                              input logic [31:0] rpc, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] data, input logic [31:0] e_addr,
                              input logic [1:0] e_pb, input logic e_pred, input logic e_flush,
                              input logic [31:0] e_pa1, input logic [31:0] e_ba1);
    vec_t v;
    v.chk = chk; v.rstn = rstn; v.pw = pw; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc;
    v.ut = ut; v.data = data; v.e_addr = e_addr; v.e_pb = e_pb; v.e_pred = e_pred;
    v.e_flush = e_flush; v.e_pa1 = e_pa1; v.e_ba1 = e_ba1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % NENT);
  endfunction

  function automatic int sat(input int c, input logic t);
    if (t) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  function automatic logic is_branch(input logic [31:0] d);
    return (d[31:26] == 6'd4) || (d[31:26] == 6'd5);
  endfunction

  // counter value the fetch side should observe this cycle
  function automatic int model_pb();
    int c;
    c = m_ctr[idx_of(m_pc)];
`ifdef BHT_BYPASS_EN
    if (upd_valid && idx_of(upd_pc) == idx_of(m_pc)) c = sat(c, upd_taken);
`endif
    return c;
  endfunction

  function automatic logic [31:0] model_ba1();
    int off;
    off = int'($signed(imem_data[15:0])) * 4;
    return m_pc + 32'd4 + off;
  endfunction

  task automatic model_edge();
    logic        pred;
    logic [31:0] pa;
    if (!rst_n) begin
      m_pc = RST_PC;
      for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
    end else begin
      pred = is_branch(imem_data) && (model_pb() >= 2);
      pa   = m_pc + 32'd4;
      if (redirect_valid)                  m_pc = redirect_pc;
      else if (!pc_write)                  m_pc = m_pc;
      else if (pred)                       m_pc = model_ba1();
      else if (imem_data[31:26] == 6'd2)   m_pc = (pa & 32'hF000_0000) | ((imem_data & 32'h03FF_FFFF) << 2);
      else                                 m_pc = pa;
      if (upd_valid) m_ctr[idx_of(upd_pc)] = sat(m_ctr[idx_of(upd_pc)], upd_taken);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n = v.rstn; pc_write = v.pw; redirect_valid = v.rv; redirect_pc = v.rpc;
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut; imem_data = v.data;
  endtask

  initial begin
    logic [1:0]  pb17;
    logic [31:0] d;
    int          p;
`ifdef BHT_BYPASS_EN
    pb17 = 2'b10;
`else
    pb17 = 2'b01;
`endif
    //         chk  rstn pw   rv   rpc           uv   upc           ut   data          addr          pb     pred flush pcaddr1       branchaddr1
    vt[0]  = mk(1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b01,1'b0,1'b0,32'h0,        32'h0);
    vt[1]  = mk(1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b01,1'b0,1'b0,32'h0,        32'h0);
    vt[2]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_0004,32'h0,        2'b01,1'b0,1'b0,32'h4,        32'h14);
    vt[3]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'h0,        32'h4,        2'b01,1'b0,1'b0,32'h8,        32'h8);
    vt[4]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'h0,        32'h8,        2'b01,1'b0,1'b0,32'hC,        32'hC);
    vt[5]  = mk(1'b1,1'b1,1'b1,1'b1,32'h0,        1'b1,32'h0,        1'b1,32'h0,        32'hC,        2'b01,1'b0,1'b1,32'h10,       32'h10);
    vt[6]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_0004,32'h0,        2'b11,1'b1,1'b0,32'h4,        32'h14);
    vt[7]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h14,       2'b01,1'b0,1'b0,32'h18,       32'h18);
    vt[8]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h18,       2'b01,1'b0,1'b0,32'h1C,       32'h1C);
    vt[9]  = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h1C,       2'b01,1'b0,1'b0,32'h20,       32'h20);
    vt[10] = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0800_0010,32'h20,       2'b01,1'b0,1'b0,32'h24,       32'h64);
    vt[11] = mk(1'b1,1'b1,1'b1,1'b1,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h40,       2'b01,1'b0,1'b1,32'h44,       32'h44);
    vt[12] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_0004,32'h0,        2'b00,1'b0,1'b0,32'h4,        32'h14);
    vt[13] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h4,        32'h4);
    vt[14] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b0,32'h4,        32'h4);
    vt[15] = mk(1'b1,1'b1,1'b0,1'b1,32'h100,      1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b00,1'b0,1'b1,32'h4,        32'h4);
    vt[16] = mk(1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h100,      2'b00,1'b0,1'b0,32'h104,      32'h104);
    vt[17] = mk(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b1,32'h0,        32'h0,        pb17, 1'b0,1'b0,32'h4,        32'h4);
    vt[18] = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_0004,32'h0,        2'b10,1'b1,1'b0,32'h4,        32'h14);
    vt[19] = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1400_0008,32'h14,       2'b01,1'b0,1'b0,32'h18,       32'h38);
    vt[20] = mk(1'b1,1'b1,1'b1,1'b1,32'hFFFF_FFFC,1'b0,32'h0,        1'b0,32'h0,        32'h18,       2'b01,1'b0,1'b1,32'h1C,       32'h1C);
    vt[21] = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1000_FFFF,32'hFFFF_FFFC,2'b01,1'b0,1'b0,32'h0,        32'hFFFF_FFFC);
    vt[22] = mk(1'b1,1'b0,1'b1,1'b1,32'h200,      1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b10,1'b0,1'b1,32'h4,        32'h4);
    vt[23] = mk(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        2'b01,1'b0,1'b0,32'h4,        32'h4);

    for (int i = 0; i < 24; i++) begin
      drive(vt[i]);
      #2;
      if (vt[i].chk) begin
        check($sformatf("v%0d imem_addr", i), imem_addr, vt[i].e_addr);
        check($sformatf("v%0d predictionbuffer", i), {30'd0, predictionbuffer}, {30'd0, vt[i].e_pb});
        check($sformatf("v%0d predict", i), {31'd0, predict}, {31'd0, vt[i].e_pred});
        check($sformatf("v%0d if_flush", i), {31'd0, if_flush}, {31'd0, vt[i].e_flush});
        check($sformatf("v%0d pcaddr1", i), pcaddr1, vt[i].e_pa1);
        check($sformatf("v%0d branchaddr1", i), branchaddr1, vt[i].e_ba1);
      end
      @(posedge clk);
      model_edge();
      #1;
    end

    // random phase: start from a fresh reset so the model is fully known
    for (int c = 0; c < 600; c++) begin
      rst_n          = (c < 2) ? 1'b0 : ($urandom_range(0, 63) != 0);
      pc_write       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 15) == 0) redirect_pc = $urandom;
      upd_valid      = $urandom_range(0, 1) == 1;
      upd_pc         = ($urandom_range(0, 2) == 0) ? m_pc : (32'($urandom_range(0, 255)) << 2);
      upd_taken      = $urandom_range(0, 1) == 1;
      d = $urandom;
      p = int'($urandom_range(0, 4));
      case (p)
        0: d[31:26] = 6'h04;
        1: d[31:26] = 6'h05;
        2: d[31:26] = 6'h02;
        3: d[15:0]  = 16'($urandom_range(0, 15)) - 16'd8;
        default: d = d;
      endcase
      imem_data = d;
      #2;
      if (c >= 2) begin
        check("rnd imem_addr", imem_addr, m_pc);
        check("rnd ins", ins, imem_data);
        check("rnd pcaddr1", pcaddr1, m_pc + 32'd4);
        check("rnd signextend", signextendresult, 32'(int'($signed(imem_data[15:0]))));
        check("rnd branchaddr1", branchaddr1, model_ba1());
        check("rnd predictionbuffer", {30'd0, predictionbuffer}, 32'(model_pb()));
        check("rnd predict", {31'd0, predict}, {31'd0, is_branch(imem_data) && (model_pb() >= 2)});
        check("rnd if_flush", {31'd0, if_flush}, {31'd0, redirect_valid});
      end
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
